// File: rtl/bp_stall_histogram.sv
// Per-core stall histogram: bins each cycle's verdict into saturating
// counters and streams a snapshot of them out over valid/ready.
module bp_stall_histogram #(
  parameter int num_reasons_p = 22,
  parameter int cnt_width_p = 32,
  parameter int window_cycles_p = 1024,
  localparam int num_bins = num_reasons_p + 2,
  localparam int bin_width = $clog2(num_bins)
) (
  input  logic                   clk_i,
  input  logic                   reset_li,
  input  logic                   en_i,
  input  logic                   instr_v_i,
  input  logic                   stall_v_i,
  input  logic [4:0]             stall_reason_i,
  input  logic                   clear_i,
  input  logic                   dump_req_i,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic [bin_width-1:0]   bin_o,
  output logic [cnt_width_p-1:0] data_o,
  output logic                   last_o,
  output logic                   overrun_o
);

  localparam int win_width = $clog2(window_cycles_p);
  localparam int instr_bin = num_reasons_p;
  localparam int unk_bin = num_reasons_p + 1;

  typedef enum logic {IDLE, DUMP} state_e;

  state_e                 state_q;
  logic [bin_width-1:0]   beat_q;
  logic [win_width-1:0]   win_q;
  logic [cnt_width_p-1:0] live_q [num_bins];
  logic [cnt_width_p-1:0] shadow_q [num_bins];
  logic [cnt_width_p-1:0] live_n [num_bins];
  logic [bin_width-1:0]   inc_bin;
  logic                   wrap;
  logic                   trig;
  logic                   at_last;

  always_comb begin
    inc_bin = bin_width'(unk_bin);
    if (instr_v_i)
      inc_bin = bin_width'(instr_bin);
    else if (stall_v_i && int'(stall_reason_i) < num_reasons_p)
      inc_bin = bin_width'(stall_reason_i);
  end

  // Saturating increment of the single selected bin.
  always_comb begin
    for (int b = 0; b < num_bins; b++) begin
      live_n[b] = live_q[b];
      if (en_i && inc_bin == bin_width'(b) && live_q[b] != '1)
        live_n[b] = live_q[b] + cnt_width_p'(1);
    end
  end

  assign wrap = en_i && (win_q == win_width'(window_cycles_p - 1));
  assign trig = (wrap || dump_req_i) && !clear_i;
  assign at_last = (beat_q == bin_width'(num_bins - 1));

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_q <= IDLE;
      beat_q <= '0;
      win_q <= '0;
      overrun_o <= 1'b0;
      for (int b = 0; b < num_bins; b++) begin
        live_q[b] <= '0;
        shadow_q[b] <= '0;
      end
    end else begin
      if (state_q == DUMP && ready_i) begin
        if (at_last) begin
          beat_q <= '0;
          state_q <= IDLE;
        end else begin
          beat_q <= beat_q + bin_width'(1);
        end
      end
      if (clear_i) begin
        win_q <= '0;
        overrun_o <= 1'b0;
        for (int b = 0; b < num_bins; b++)
          live_q[b] <= '0;
      end else begin
        if (en_i)
          win_q <= wrap ? '0 : win_q + win_width'(1);
        if (state_q == IDLE && trig) begin
          win_q <= '0;
          state_q <= DUMP;
          for (int b = 0; b < num_bins; b++) begin
            shadow_q[b] <= live_n[b];
            live_q[b] <= '0;
          end
        end else begin
          // A snapshot in flight cannot be replaced; keep counting.
          if (state_q == DUMP && wrap)
            overrun_o <= 1'b1;
          for (int b = 0; b < num_bins; b++)
            live_q[b] <= live_n[b];
        end
      end
    end
  end

  assign v_o = (state_q == DUMP);
  assign bin_o = beat_q;
  assign data_o = v_o ? shadow_q[beat_q] : '0;
  assign last_o = v_o && at_last;

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Directed bench for bp_stall_histogram: two instances, one with an
// 8-cycle window and one with 4-bit counters for saturation.
module tb_bp_stall_histogram;

  logic clk = 1'b0;
  logic rst_n;
  logic en, instr, stallv, clear, dreq, rdy, sel;
  logic [4:0] reason;
  logic v, last, ovr;
  logic [4:0] bin;
  logic [31:0] data;

  logic s_en, s_instr, s_stallv, s_clear, s_dreq;
  logic [4:0] s_reason;
  logic s_v, s_last, s_ovr;
  logic [4:0] s_bin;
  logic [3:0] s_data;

  int compared = 0;
  int mismatched = 0;
  int beats, stable_bad, last_bad, tmo;
  logic [31:0] got [24];
  logic [31:0] exp_b [24];

  wire cv = sel ? s_v : v;
  wire [4:0] cb = sel ? s_bin : bin;
  wire [31:0] cd = sel ? {28'd0, s_data} : data;
  wire cl = sel ? s_last : last;

  always #5 clk = ~clk;

  bp_stall_histogram #(
    .num_reasons_p(22), .cnt_width_p(32), .window_cycles_p(8)
  ) dut (
    .clk_i(clk), .reset_li(rst_n), .en_i(en), .instr_v_i(instr),
    .stall_v_i(stallv), .stall_reason_i(reason), .clear_i(clear),
    .dump_req_i(dreq), .v_o(v), .ready_i(rdy & ~sel), .bin_o(bin),
    .data_o(data), .last_o(last), .overrun_o(ovr)
  );

  bp_stall_histogram #(
    .num_reasons_p(22), .cnt_width_p(4), .window_cycles_p(1024)
  ) dut_s (
    .clk_i(clk), .reset_li(rst_n), .en_i(s_en), .instr_v_i(s_instr),
    .stall_v_i(s_stallv), .stall_reason_i(s_reason), .clear_i(s_clear),
    .dump_req_i(s_dreq), .v_o(s_v), .ready_i(rdy & sel), .bin_o(s_bin),
    .data_o(s_data), .last_o(s_last), .overrun_o(s_ovr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic e, input logic i, input logic s,
                      input logic [4:0] r);
    en = e; instr = i; stallv = s; reason = r;
    cyc();
    en = 0; instr = 0; stallv = 0; reason = 0;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 24; i++) exp_b[i] = 0;
  endtask

  // Drains one dump on the selected instance into got[]; ready is
  // either held high or toggled 1,0,1,0.
  task automatic collect(input bit alt);
    int t;
    logic [4:0] pb;
    logic [31:0] pd;
    logic pl;
    beats = 0; stable_bad = 0; last_bad = 0; tmo = 0;
    for (int i = 0; i < 24; i++) got[i] = 'x;
    t = 0;
    while (!cv && t < 50) begin cyc(); t++; end
    if (!cv) begin tmo = 1; return; end
    t = 0;
    while (t < 200) begin
      if (!cv) begin tmo = 1; break; end
      rdy = alt ? (t % 2 == 0) : 1'b1;
      pb = cb; pd = cd; pl = cl;
      cyc();
      t++;
      if (!rdy) begin
        if (cb !== pb || cd !== pd || cl !== pl) stable_bad++;
      end else begin
        got[pb] = pd;
        if (pl !== (pb == 5'd23)) last_bad++;
        beats++;
        if (pl) break;
      end
    end
    rdy = 0;
    if (t >= 200) tmo = 1;
  endtask

  task automatic test_reset();
    compared++;
    if (v !== 1'b0) begin mismatched++; $display("FAIL reset_v: got %b want 0", v); end
    compared++;
    if (bin !== 5'd0) begin mismatched++; $display("FAIL reset_bin: got %0d want 0", bin); end
    compared++;
    if (data !== 32'd0) begin mismatched++; $display("FAIL reset_data: got %0d want 0", data); end
    compared++;
    if (last !== 1'b0) begin mismatched++; $display("FAIL reset_last: got %b want 0", last); end
    compared++;
    if (ovr !== 1'b0) begin mismatched++; $display("FAIL reset_ovr: got %b want 0", ovr); end
  endtask

  task automatic test_instr_window();
    en = 1; instr = 1;
    repeat (7) cyc();
    compared++;
    if (v !== 1'b0) begin mismatched++; $display("FAIL win_early_v: got %b want 0", v); end
    cyc();
    en = 0; instr = 0;
    compared++;
    if (v !== 1'b1 || bin !== 5'd0) begin
      mismatched++; $display("FAIL win_v: got v=%b bin=%0d want v=1 bin=0", v, bin);
    end
    collect(0);
    clr_exp(); exp_b[22] = 8;
    for (int i = 0; i < 24; i++) begin
      compared++;
      if (got[i] !== exp_b[i]) begin
        mismatched++; $display("FAIL win_bin%0d: got %0d want %0d", i, got[i], exp_b[i]);
      end
    end
    compared++;
    if (beats !== 24 || tmo !== 0 || last_bad !== 0) begin
      mismatched++;
      $display("FAIL win_beats: got %0d tmo=%0d lastbad=%0d want 24 0 0", beats, tmo, last_bad);
    end
    compared++;
    if (v !== 1'b0) begin mismatched++; $display("FAIL win_idle: got v=%b want 0", v); end
  endtask

  task automatic test_mixed();
    repeat (3) step(1, 0, 1, 5'd4);
    repeat (2) step(1, 0, 1, 5'd31);
    dreq = 1;
    step(1, 1, 0, 5'd0);
    dreq = 0;
    collect(0);
    clr_exp(); exp_b[4] = 3; exp_b[23] = 2; exp_b[22] = 1;
    for (int i = 0; i < 24; i++) begin
      compared++;
      if (got[i] !== exp_b[i]) begin
        mismatched++; $display("FAIL mix_bin%0d: got %0d want %0d", i, got[i], exp_b[i]);
      end
    end
    compared++;
    if (beats !== 24 || tmo !== 0) begin
      mismatched++; $display("FAIL mix_beats: got %0d tmo=%0d want 24 0", beats, tmo);
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, 1, 5'd1);
    repeat (2) step(1, 0, 1, 5'd2);
    step(1, 0, 1, 5'd21);
    step(1, 0, 0, 5'd3);
    repeat (2) step(1, 1, 0, 5'd0);
    dreq = 1;
    cyc();
    dreq = 0;
    collect(1);
    clr_exp(); exp_b[1] = 1; exp_b[2] = 2; exp_b[21] = 1;
    exp_b[23] = 1; exp_b[22] = 2;
    for (int i = 0; i < 24; i++) begin
      compared++;
      if (got[i] !== exp_b[i]) begin
        mismatched++; $display("FAIL bp_bin%0d: got %0d want %0d", i, got[i], exp_b[i]);
      end
    end
    compared++;
    if (stable_bad !== 0) begin
      mismatched++; $display("FAIL bp_stable: got %0d changes want 0", stable_bad);
    end
    compared++;
    if (beats !== 24 || tmo !== 0 || last_bad !== 0) begin
      mismatched++;
      $display("FAIL bp_beats: got %0d tmo=%0d lastbad=%0d want 24 0 0", beats, tmo, last_bad);
    end
    compared++;
    if (v !== 1'b0) begin mismatched++; $display("FAIL bp_idle: got v=%b want 0", v); end
  endtask

  task automatic test_overrun();
    en = 1; instr = 1;
    repeat (8) cyc();
    compared++;
    if (v !== 1'b1) begin mismatched++; $display("FAIL ovr_dump: got v=%b want 1", v); end
    repeat (7) cyc();
    compared++;
    if (ovr !== 1'b0) begin mismatched++; $display("FAIL ovr_early: got %b want 0", ovr); end
    cyc();
    en = 0; instr = 0;
    compared++;
    if (ovr !== 1'b1) begin mismatched++; $display("FAIL ovr_set: got %b want 1", ovr); end
    collect(0);
    compared++;
    if (got[22] !== 32'd8 || tmo !== 0) begin
      mismatched++; $display("FAIL ovr_first: got bin22=%0d tmo=%0d want 8 0", got[22], tmo);
    end
    en = 1; instr = 1;
    repeat (8) cyc();
    en = 0; instr = 0;
    collect(0);
    compared++;
    if (got[22] !== 32'd16 || tmo !== 0) begin
      mismatched++; $display("FAIL ovr_carry: got bin22=%0d tmo=%0d want 16 0", got[22], tmo);
    end
    compared++;
    if (ovr !== 1'b1) begin mismatched++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
    clear = 1;
    cyc();
    clear = 0;
    compared++;
    if (ovr !== 1'b0) begin mismatched++; $display("FAIL ovr_clear: got %b want 0", ovr); end
  endtask

  task automatic test_async_reset();
    repeat (3) step(1, 0, 1, 5'd5);
    dreq = 1;
    cyc();
    dreq = 0;
    rdy = 1;
    repeat (5) cyc();
    rdy = 0;
    compared++;
    if (v !== 1'b1 || bin !== 5'd5 || data !== 32'd3) begin
      mismatched++;
      $display("FAIL ar_beat5: got v=%b bin=%0d data=%0d want 1 5 3", v, bin, data);
    end
    #2 rst_n = 0;
    #1;
    compared++;
    if (v !== 1'b0 || bin !== 5'd0) begin
      mismatched++; $display("FAIL ar_drop: got v=%b bin=%0d want 0 0", v, bin);
    end
    #2 rst_n = 1;
    cyc();
    dreq = 1;
    cyc();
    dreq = 0;
    collect(0);
    for (int i = 0; i < 24; i++) begin
      compared++;
      if (got[i] !== 32'd0) begin
        mismatched++; $display("FAIL ar_bin%0d: got %0d want 0", i, got[i]);
      end
    end
  endtask

  task automatic test_saturation();
    sel = 1;
    s_en = 1; s_instr = 1;
    repeat (20) cyc();
    s_en = 0; s_instr = 0;
    s_dreq = 1;
    cyc();
    s_dreq = 0;
    collect(0);
    compared++;
    if (got[22] !== 32'd15 || got[21] !== 32'd0 || tmo !== 0) begin
      mismatched++;
      $display("FAIL sat_bin22: got %0d bin21=%0d tmo=%0d want 15 0 0", got[22], got[21], tmo);
    end
    s_en = 1; s_instr = 1;
    repeat (3) cyc();
    s_clear = 1; s_dreq = 1;
    cyc();
    s_clear = 0; s_dreq = 0; s_en = 0; s_instr = 0;
    compared++;
    if (s_v !== 1'b0) begin mismatched++; $display("FAIL sat_clr_nodump: got v=%b want 0", s_v); end
    s_dreq = 1;
    cyc();
    s_dreq = 0;
    collect(0);
    compared++;
    if (got[22] !== 32'd0 || tmo !== 0) begin
      mismatched++; $display("FAIL sat_clr_zero: got bin22=%0d tmo=%0d want 0 0", got[22], tmo);
    end
    sel = 0;
  endtask

  initial begin
    rst_n = 0; sel = 0; rdy = 0;
    en = 0; instr = 0; stallv = 0; reason = 0; clear = 0; dreq = 0;
    s_en = 0; s_instr = 0; s_stallv = 0; s_reason = 0; s_clear = 0; s_dreq = 0;
    repeat (2) cyc();
    test_reset();
    rst_n = 1;
    cyc();
    test_instr_window();
    test_mixed();
    test_backpressure();
    test_overrun();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
